// File: rtl/mfu_add_writeback_if.sv
// Adder-result / VRF-write bundle for the MFU add writeback block.
// The master side issues jobs, supplies results and VRF backpressure; the slave side writes the VRF.
interface mfu_add_writeback_if #(
  parameter int DESIGN_SIZE = 10,
  parameter int DWIDTH      = 16,
  parameter int AWIDTH      = 8
);
  logic                          start;
  logic [AWIDTH-1:0]             base_addr;
  logic [AWIDTH-1:0]             num_vectors;
  logic                          result_valid;
  logic [DESIGN_SIZE*DWIDTH-1:0] result_data;
  logic                          vrf_ready;
  logic                          vrf_we;
  logic [AWIDTH-1:0]             vrf_addr;
  logic [DESIGN_SIZE*DWIDTH-1:0] vrf_wdata;
  logic                          busy;
  logic                          done;
  logic                          overflow;

  modport master (
    output start, base_addr, num_vectors, result_valid, result_data, vrf_ready,
    input  vrf_we, vrf_addr, vrf_wdata, busy, done, overflow
  );

  modport slave (
    input  start, base_addr, num_vectors, result_valid, result_data, vrf_ready,
    output vrf_we, vrf_addr, vrf_wdata, busy, done, overflow
  );
endinterface

// File: rtl/mfu_add_writeback.sv
// Buffers adder result vectors in a small FIFO and writes them to consecutive VRF
// addresses; one job = num_vectors results starting at base_addr.
module mfu_add_writeback #(
  parameter int DESIGN_SIZE = 10,
  parameter int DWIDTH      = 16,
  parameter int AWIDTH      = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input logic                clk,
  input logic                reset,
  mfu_add_writeback_if.slave wb
);
  localparam int VW = DESIGN_SIZE * DWIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [AWIDTH-1:0] base;
    logic [AWIDTH-1:0] num;
  } job_t;

  state_t                     state, state_nx;
  job_t                       job;
  logic [AWIDTH-1:0]          acc_cnt, wr_cnt;
  logic [FIFO_DEPTH-1:0][VW-1:0] mem;
  logic [PW-1:0]              wptr, rptr;
  logic [PW:0]                count;
  logic                       vrf_we_q, overflow_q;
  logic [AWIDTH-1:0]          vrf_addr_q;
  logic [VW-1:0]              vrf_wdata_q;

  logic run, full, accept, pop, push, drop, launch;

  assign run    = (state == RUN);
  assign full   = (count == FULL_CNT);
  assign launch = (state == IDLE) && wb.start;
  assign pop    = run && (count != '0) && wb.vrf_ready;
  // A full FIFO still takes a result when the head leaves on the same edge.
  assign accept = run && wb.result_valid && (acc_cnt < job.num);
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (wb.start) state_nx = (wb.num_vectors == '0) ? DONE : RUN;
      RUN:  if (wr_cnt == job.num) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Storage carries no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wb.result_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job         <= '0;
      acc_cnt     <= '0;
      wr_cnt      <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      vrf_we_q    <= 1'b0;
      vrf_addr_q  <= '0;
      vrf_wdata_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      vrf_we_q <= pop;
      if (launch) begin
        job        <= '{base: wb.base_addr, num: wb.num_vectors};
        acc_cnt    <= '0;
        wr_cnt     <= '0;
        wptr       <= '0;
        rptr       <= '0;
        count      <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) begin
          wptr    <= wptr + 1'b1;
          acc_cnt <= acc_cnt + 1'b1;
        end
        if (pop) begin
          vrf_addr_q  <= job.base + wr_cnt;
          vrf_wdata_q <= mem[rptr];
          rptr        <= rptr + 1'b1;
          wr_cnt      <= wr_cnt + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (drop) overflow_q <= 1'b1;
      end
    end
  end

  assign wb.vrf_we    = vrf_we_q;
  assign wb.vrf_addr  = vrf_addr_q;
  assign wb.vrf_wdata = vrf_wdata_q;
  assign wb.busy      = run;
  assign wb.done      = (state == DONE);
  assign wb.overflow  = overflow_q;
endmodule
